// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states and result constants.
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'h0;
  localparam logic [3:0] MDU_MULT  = 4'h1;
  localparam logic [3:0] MDU_MULTU = 4'h2;
  localparam logic [3:0] MDU_DIV   = 4'h3;
  localparam logic [3:0] MDU_DIVU  = 4'h4;
  localparam logic [3:0] MDU_MTHI  = 4'h5;
  localparam logic [3:0] MDU_MTLO  = 4'h6;
  localparam logic [3:0] MDU_MADD  = 4'h7;
  localparam logic [3:0] MDU_MADDU = 4'h8;
  localparam logic [3:0] MDU_MSUB  = 4'h9;
  localparam logic [3:0] MDU_MSUBU = 4'hA;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // What the FIX edge does with the iterated magnitudes.
  typedef enum logic [1:0] {
    K_MUL  = 2'd0,
    K_DIV  = 2'd1,
    K_MADD = 2'd2,
    K_MSUB = 2'd3
  } kind_t;

  localparam int MAX_W = 64;

  // Quotient reported on a zero divisor; sliced down to the operand width.
  localparam logic [MAX_W-1:0] DIV0_QUOT = '1;

  function automatic logic op_signed(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV) ||
           (op == MDU_MADD) || (op == MDU_MSUB);
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// E-stage to MDU connection: start/busy handshake, abort request, operands and the HI/LO view.
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             req;
  logic [3:0]       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, req, op, op_a, op_b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, req, op, op_a, op_b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_iter_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step on unsigned magnitudes.
module mdu_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic             mul_sel,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_hi_nxt,
  output logic [WIDTH-1:0] acc_lo_nxt
);

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff_lo;
  logic             fits;

  // Multiply: acc_hi is the partial product, acc_lo the multiplier being consumed LSB first.
  // Divide:   acc_hi is the running remainder, acc_lo the dividend turning into the quotient.
  always_comb begin
    add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    fits    = (shifted >= {1'b0, opnd});
    // When it fits the true difference is below opnd, so the low WIDTH bits are exact.
    diff_lo = shifted[WIDTH-1:0] - opnd;

    if (mul_sel) begin
      acc_hi_nxt = add_sum[WIDTH:1];
      acc_lo_nxt = {add_sum[0], acc_lo[WIDTH-1:1]};
    end else begin
      acc_hi_nxt = fits ? diff_lo : shifted[WIDTH-1:0];
      acc_lo_nxt = {acc_lo[WIDTH-2:0], fits};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative HI/LO multiply/divide unit, one bit per cycle; results commit only on completion.
// Optional MDU_MADD_EN adds madd/maddu/msub/msubu accumulating into HI/LO.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  mdu_iter_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  kind_t            kind_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q, a_raw_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             neg_res_q, neg_rem_q, div0_q, done_q;

  logic             dec_calc;
  kind_t            dec_kind;
  logic             dec_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic             accept, iterate, commit, wr_hi, wr_lo;
  logic [WIDTH-1:0] step_hi, step_lo;

  logic [2*WIDTH-1:0] prod_mag, prod, res;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    dec_calc   = 1'b0;
    dec_kind   = K_MUL;
    dec_signed = op_signed(bus.op);
    case (bus.op)
      MDU_MULT, MDU_MULTU: begin
        dec_calc = 1'b1;
        dec_kind = K_MUL;
      end
      MDU_DIV, MDU_DIVU: begin
        dec_calc = 1'b1;
        dec_kind = K_DIV;
      end
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU: begin
        dec_calc = 1'b1;
        dec_kind = K_MADD;
      end
      MDU_MSUB, MDU_MSUBU: begin
        dec_calc = 1'b1;
        dec_kind = K_MSUB;
      end
`endif
      default: ;
    endcase

    a_neg = dec_signed & bus.op_a[WIDTH-1];
    b_neg = dec_signed & bus.op_b[WIDTH-1];
    a_mag = a_neg ? -bus.op_a : bus.op_a;
    b_mag = b_neg ? -bus.op_b : bus.op_b;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    iterate = 1'b0;
    commit  = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.req) begin
          accept = dec_calc;
          wr_hi  = (bus.op == MDU_MTHI);
          wr_lo  = (bus.op == MDU_MTLO);
          if (dec_calc) state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (bus.req) begin
          state_d = S_IDLE;
        end else begin
          iterate = 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        commit  = !bus.req;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .mul_sel    (kind_q != K_DIV),
    .acc_hi     (acc_hi_q),
    .acc_lo     (acc_lo_q),
    .opnd       (opnd_q),
    .acc_hi_nxt (step_hi),
    .acc_lo_nxt (step_lo)
  );

  // Working registers: loaded at accept, advanced once per CALC edge, never touch HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kind_q    <= K_MUL;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else if (accept) begin
      kind_q    <= dec_kind;
      cnt_q     <= CNT_W'(WIDTH);
      acc_hi_q  <= '0;
      acc_lo_q  <= (dec_kind == K_DIV) ? a_mag : b_mag;
      opnd_q    <= (dec_kind == K_DIV) ? b_mag : a_mag;
      a_raw_q   <= bus.op_a;
      neg_res_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      div0_q    <= (bus.op_b == '0);
    end else if (iterate) begin
      acc_hi_q  <= step_hi;
      acc_lo_q  <= step_lo;
      cnt_q     <= cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    prod_mag = {acc_hi_q, acc_lo_q};
    prod     = neg_res_q ? -prod_mag : prod_mag;
    quo      = neg_res_q ? -acc_lo_q : acc_lo_q;
    rem      = neg_rem_q ? -acc_hi_q : acc_hi_q;
    res      = prod;
    case (kind_q)
      K_DIV:   res = div0_q ? {a_raw_q, DIV0_QUOT[WIDTH-1:0]} : {rem, quo};
`ifdef MDU_MADD_EN
      // Accumulator is sampled here, at commit, so mthi/mtlo issued earlier are honoured.
      K_MADD:  res = {hi_q, lo_q} + prod;
      K_MSUB:  res = {hi_q, lo_q} - prod;
`endif
      default: res = prod;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= commit;
      if (commit) begin
        hi_q <= res[2*WIDTH-1:WIDTH];
        lo_q <= res[WIDTH-1:0];
      end else begin
        if (wr_hi) hi_q <= bus.op_a;
        if (wr_lo) lo_q <= bus.op_a;
      end
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: directed ops push expected HI/LO, a monitor checks each done pulse.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int W = 32;

  typedef struct {
    string          name;
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  mdu_iter_if #(.WIDTH(W)) bus ();

  mdu_iter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = o;
    bus.op_a  = a;
    bus.op_b  = b;
    cyc();
    bus.start = 1'b0;
    bus.op    = MDU_NONE;
  endtask

  task automatic run_op(input string name, input logic [3:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    exp_t e;
    int   n;
    int   d0;
    e.name = name;
    e.hi   = ehi;
    e.lo   = elo;
    sb_q.push_back(e);
    d0 = done_cnt;
    issue(o, a, b);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      cyc();
    end
    check({name, "_busy_cycles"}, 64'(n), 64'(W + 1));
    cyc();
    check({name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
  endtask

  // Monitor: every done pulse consumes one expected result.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && bus.done === 1'b1) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got hi=%h lo=%h, required no result", bus.hi, bus.lo);
        end else begin
          mon_e = sb_q.pop_front();
          check({mon_e.name, "_hi"}, 64'(bus.hi), 64'(mon_e.hi));
          check({mon_e.name, "_lo"}, 64'(bus.lo), 64'(mon_e.lo));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bus.start = 1'b0;
    bus.req   = 1'b0;
    bus.op    = MDU_NONE;
    bus.op_a  = '0;
    bus.op_b  = '0;
    reset     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi",   64'(bus.hi),   64'd0);
    check("rst_lo",   64'(bus.lo),   64'd0);
    reset = 1'b1;
    cyc();

    run_op("mult_neg",  MDU_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("divu",      MDU_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);
    run_op("div_neg_a", MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_neg_b", MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
    run_op("div_ovf",   MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
    run_op("divu_zero", MDU_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF);

    issue(MDU_MTHI, 32'h0000_1234, 32'd0);
    check("mthi_busy", 64'(bus.busy), 64'd0);
    check("mthi_hi",   64'(bus.hi),   64'h1234);
    check("mthi_lo",   64'(bus.lo),   64'hFFFF_FFFF);

    // Abort during the tenth CALC cycle.
    d0 = done_cnt;
    issue(MDU_MULT, 32'd6, 32'd7);
    repeat (9) cyc();
    check("abort_busy_before", 64'(bus.busy), 64'd1);
    bus.req = 1'b1;
    cyc();
    bus.req = 1'b0;
    check("abort_busy_after", 64'(bus.busy), 64'd0);
    repeat (40) cyc();
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_hi", 64'(bus.hi), 64'h1234);
    check("abort_lo", 64'(bus.lo), 64'hFFFF_FFFF);

    issue(MDU_MTLO, 32'd55, 32'd0);
    check("mtlo_lo", 64'(bus.lo), 64'd55);

`ifdef MDU_MADD_EN
    issue(MDU_MTLO, 32'd10, 32'd0);
    issue(MDU_MTHI, 32'd0, 32'd0);
    run_op("madd",  MDU_MADD,  32'd3,         32'd4, 32'd0,         32'd22);
    run_op("msubu", MDU_MSUBU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'h0000_0018);
`else
    d0 = done_cnt;
    issue(MDU_MADD, 32'd3, 32'd4);
    check("madd_off_busy", 64'(bus.busy), 64'd0);
    repeat (40) cyc();
    check("madd_off_no_done", 64'(done_cnt - d0), 64'd0);
    check("madd_off_hi", 64'(bus.hi), 64'h1234);
    check("madd_off_lo", 64'(bus.lo), 64'd55);
`endif

    // Asynchronous reset between clock edges, mid-CALC.
    issue(MDU_MULT, 32'd6, 32'd7);
    repeat (5) cyc();
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_busy", 64'(bus.busy), 64'd0);
    check("async_rst_hi",   64'(bus.hi),   64'd0);
    check("async_rst_lo",   64'(bus.lo),   64'd0);
    #2;
    reset = 1'b1;
    cyc();

    d0 = done_cnt;
    bus.start = 1'b1;
    bus.req   = 1'b1;
    bus.op    = MDU_MULT;
    bus.op_a  = 32'd6;
    bus.op_b  = 32'd7;
    cyc();
    bus.start = 1'b0;
    bus.req   = 1'b0;
    bus.op    = MDU_NONE;
    check("start_req_busy", 64'(bus.busy), 64'd0);
    repeat (40) cyc();
    check("start_req_no_done", 64'(done_cnt - d0), 64'd0);
    check("start_req_lo", 64'(bus.lo), 64'd0);

    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit for the E stage of the pipelined CPU; successor to the single-shot HI/LO MDU.
- Computes a real shift-add product and restoring division at one bit per cycle over a configurable operand width.
- Holds results in working registers and commits them to HI/LO only on completion, so an exception request can abort an operation in flight without corrupting HI/LO.
- Exposes the start/busy handshake the stall logic already uses, plus a one-cycle done pulse.

Parameters:
- WIDTH, 32, operand width and HI/LO width in bits (even, 4..64).
- CNT_W, derived localparam ceil(log2(WIDTH+1)), iteration counter width; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  E-stage MDU instruction valid this cycle.
- req  in  1  exception/interrupt request; blocks accept and aborts an in-flight op.
- op  in  4  0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo, 0111 madd, 1000 maddu, 1001 msub, 1010 msubu.
- op_a  in  WIDTH  multiplicand/dividend, or mthi/mtlo data.
- op_b  in  WIDTH  multiplier/divisor.
- busy  out  1  operation in progress; the pipeline stalls MDU ops while it is high.
- done  out  1  one-cycle pulse on the commit edge.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset low, asynchronous): hi=0, lo=0, busy=0, done=0, state IDLE, counter=0, all working registers cleared. Reset mid-operation discards the operation.
- States are IDLE, CALC and FIX.
- Accept: IDLE && start && !req on edge E0.
  - mult/multu/div/divu go to CALC with busy=1 and counter=WIDTH.
  - Operand magnitudes and result signs are latched for signed ops.
  - mthi/mtlo write hi/lo at E0 directly; busy stays 0 and done stays 0.
  - none and undefined codes are ignored.
- start while busy=1 is ignored; the stall logic guarantees it does not occur.
- start && req in the same cycle: nothing is accepted.
- CALC: one iteration per edge on magnitudes, then counter decrements; goes to FIX when the counter reaches 1.
  - Multiply: shift-add, 2*WIDTH-bit product.
  - Divide: restoring, WIDTH-bit quotient and remainder.
- FIX: one edge applies sign correction and commits to hi/lo, pulses done=1, clears busy and returns to IDLE.
  - Signed divide: quotient sign is sign(a) xor sign(b); remainder takes the sign of the dividend.
- Timing: busy is high for exactly WIDTH+1 cycles (33 at default). New hi/lo values are visible from the cycle after the commit edge, which is edge E0+WIDTH+1.
- Abort: req=1 in CALC or FIX returns the unit to IDLE on the next edge with busy=0 and done=0. hi/lo keep their pre-op values; nothing partial is written.
- Divide by zero: lo={WIDTH{1}}, hi=op_a; full latency, no trap.
- Signed overflow (MIN / -1): lo=MIN, hi=0.
- mult/multu: hi = upper WIDTH bits, lo = lower WIDTH bits of the 2*WIDTH product; unsigned ops zero-extend.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - madd/maddu: {hi,lo} <= {hi,lo} + product at FIX.
  - msub/msubu: {hi,lo} <= {hi,lo} - product at FIX.
  - Both use 2*WIDTH modular arithmetic and the same WIDTH+1 latency.
  - The accumulator value is read at commit, not at accept.
- Undefined: codes 0111-1010 are treated as none (ignored, busy stays 0). No accumulate adder is synthesised.

Decomposition:
- Shared package mdu_pkg:
  - op-code localparams (MDU_NONE .. MDU_MSUBU);
  - state encodings (S_IDLE, S_CALC, S_FIX);
  - divide-by-zero result constant.
- One sub-module, mdu_iter_step: combinational single-iteration datapath (shift-add step and restore-subtract step), selected by a mul/div flag.
- The FSM, counter, sign fixup and commit logic stay in mdu_iter.

Test Plan:
- mult, a=0xFFFFFFFE (-2), b=3 -> busy high for 33 cycles, one done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- divu, a=100, b=7 -> lo=14, hi=2. div, a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- div, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. divu, a=5, b=0 -> lo=0xFFFFFFFF, hi=5.
- mthi 0x1234, then mult 6*7 with req=1 at cycle 10 of CALC -> busy drops the next cycle, no done pulse; hi=0x1234, lo unchanged.
- Assert reset low mid-CALC, asynchronously between edges -> busy/hi/lo go to 0 immediately. Then start together with req=1 -> nothing accepted, busy stays 0.
- With MDU_MADD_EN defined: mtlo 10, mthi 0, then madd 3*4 -> lo=22, hi=0. Then msubu 0xFFFFFFFF*2 -> {hi,lo}=0xFFFFFFFE_00000018.
